lbist_misr_ora: RTL and testbench

- Output response analyzer for the logic-BIST loop: the receiving end of the LFSR pattern generator.
- Compacts CUT responses into a signature through a multiple-input signature register (MISR).
- Counts captured patterns and, after the programmed count, compares the signature with a golden value.
- Reports done/pass to the BIST controller.

---
 rtl/lbist_misr_ora.sv | 111 +++++++++++
 tb/tb_lbist_misr_ora.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_misr_ora.sv
// -----------------------------------------------------------------------------
// lbist_misr_ora
// Output response analyzer for the logic-BIST loop. CUT responses are
// compacted into a multiple-input signature register (MISR). After the
// programmed number of captures the signature is compared against GOLDEN
// and the result is reported to the BIST controller.
//
// Handshake: din is consumed on every rising edge where din_valid=1 while the
// block is in COMPACT; there is no backpressure. In IDLE and DONE din_valid is
// ignored. start is a level sampled on the rising edge and is honoured only in
// IDLE and DONE.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a session (IDLE/DONE only)
//   din_valid  din holds a response to compact this cycle
//   din[N]     CUT response word
//   busy       high while compacting
//   done       high once the session has finished
//   pass       signature matched GOLDEN (meaningful only when done=1)
//   signature  current MISR contents
// -----------------------------------------------------------------------------
module lbist_misr_ora #(
    parameter int             N            = 32,
    parameter logic [N-1:0]   POLY         = 32'h0040_0007,
    parameter logic [N-1:0]   SEED         = '0,
    parameter logic [N-1:0]   GOLDEN       = '0,
    parameter int             NUM_PATTERNS = 1024,
    parameter int             CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         din_valid,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] signature
);

    // Count value at which the final capture happens. Holding the final index
    // (not NUM_PATTERNS itself) lets NUM_PATTERNS reach 2^CNT_W without the
    // counter ever needing to wrap.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     misr;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     misr_next;

    // Galois-style shift: the bit shifted out of the top folds back through
    // the feedback mask, then the response word is XORed in.
    always_comb begin
        misr_next = {misr[N-2:0], 1'b0} ^ (misr[N-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            misr  <= SEED;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        misr  <= SEED;
                        count <= '0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= COMPACT;
                    end
                end
                COMPACT: begin
                    if (din_valid) begin
                        misr <= misr_next;
                        if (count == LAST_IDX) begin
                            // Final capture: the compare uses the value being
                            // loaded on this edge, not the old register.
                            pass  <= (misr_next == GOLDEN);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign signature = misr;

endmodule

// File: tb/tb_lbist_misr_ora.sv
// -----------------------------------------------------------------------------
// tb_lbist_misr_ora
// Three instances of the analyzer:
//   dut_a : NUM_PATTERNS=2,  SEED=0,            GOLDEN=32'h0040_0007
//   dut_b : NUM_PATTERNS=1,  SEED=0,            GOLDEN=32'h0000_0001
//   dut_c : NUM_PATTERNS=64, CNT_W=6 (counter full range),
//           SEED=32'hACE1_0001, GOLDEN=32'h1234_5678
// Expected final {pass, signature} pairs go into per-instance queues when the
// last word of a session is driven; monitors pop them when done rises.
// -----------------------------------------------------------------------------
module tb_lbist_misr_ora;

    localparam logic [31:0] POLY     = 32'h0040_0007;
    localparam logic [31:0] GOLDEN_A = 32'h0040_0007;
    localparam logic [31:0] SEED_C   = 32'hACE1_0001;
    localparam logic [31:0] GOLDEN_C = 32'h1234_5678;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start_a, dv_a, busy_a, done_a, pass_a;
    logic [31:0] din_a, sig_a;
    logic        start_b, dv_b, busy_b, done_b, pass_b;
    logic [31:0] din_b, sig_b;
    logic        start_c, dv_c, busy_c, done_c, pass_c;
    logic [31:0] din_c, sig_c;

    lbist_misr_ora #(.N(32), .POLY(POLY), .SEED(32'h0), .GOLDEN(GOLDEN_A),
                     .NUM_PATTERNS(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .din_valid(dv_a), .din(din_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    lbist_misr_ora #(.N(32), .POLY(POLY), .SEED(32'h0), .GOLDEN(32'h1),
                     .NUM_PATTERNS(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .din_valid(dv_b), .din(din_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    lbist_misr_ora #(.N(32), .POLY(POLY), .SEED(SEED_C), .GOLDEN(GOLDEN_C),
                     .NUM_PATTERNS(64), .CNT_W(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .din_valid(dv_c), .din(din_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q_a[$];
    logic [32:0] exp_q_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Signature arithmetic over GF(2): multiply by x modulo x^32 + POLY,
    // then add the response word.
    function automatic logic [31:0] mulx(input logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ {1'b1, POLY};
        return t[31:0];
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] d);
        return mulx(s) ^ d;
    endfunction

    // ---------------- monitors ----------------
    logic done_a_q = 1'b0;
    logic done_c_q = 1'b0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && done_a && !done_a_q) begin
            if (exp_q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                e = exp_q_a.pop_front();
                check("a_final_sig", sig_a, e[31:0]);
                check("a_final_pass", {31'b0, pass_a}, {31'b0, e[32]});
            end
        end
        done_a_q = rst_n ? done_a : 1'b0;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && done_c && !done_c_q) begin
            if (exp_q_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                e = exp_q_c.pop_front();
                check("c_final_sig", sig_c, e[31:0]);
                check("c_final_pass", {31'b0, pass_c}, {31'b0, e[32]});
            end
        end
        done_c_q = rst_n ? done_c : 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic st, input logic dv, input logic [31:0] d);
        if (which == 0) begin
            start_a = st; dv_a = dv; din_a = d;
        end else begin
            start_c = st; dv_c = dv; din_c = d;
        end
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 0) ? exp_q_a.size() : exp_q_c.size()) != 0 && n < 20) begin
            tick();
            n++;
        end
        check((which == 0) ? "a_drain" : "c_drain",
              (which == 0) ? exp_q_a.size() : exp_q_c.size(), 32'd0);
    endtask

    // Full session of n captures with random gaps; optionally steers the last
    // word so the signature lands exactly on the golden value.
    task automatic session(input int which, input int n, input logic [31:0] seed,
                           input logic [31:0] golden, input bit hit);
        logic [31:0] sig;
        logic [31:0] w;
        sig = seed;
        drive(which, 1'b1, 1'b0, $urandom);
        tick();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                drive(which, 1'b0, 1'b0, $urandom);
                tick();
            end
            w = $urandom;
            if (i == n - 1 && hit) w = mulx(sig) ^ golden;
            sig = step(sig, w);
            if (i == n - 1) begin
                if (which == 0) exp_q_a.push_back({sig == golden, sig});
                else            exp_q_c.push_back({sig == golden, sig});
            end
            drive(which, 1'b0, 1'b1, w);
            tick();
        end
        drive(which, 1'b0, 1'b0, 32'h0);
        drain(which);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [31:0] w1, w2, hold;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0);
        start_b = 1'b0; dv_b = 1'b0; din_b = 32'h0;
        repeat (2) tick();

        // Reset values.
        check("rst_sig", sig_a, 32'h0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_pass", {31'b0, pass_a}, 32'd0);
        check("rst_sig_c", sig_c, SEED_C);
        rst_n = 1'b1;

        // Idle ignores din_valid.
        drive(0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        repeat (4) tick();
        check("idle_sig", sig_a, 32'h0);
        check("idle_busy", {31'b0, busy_a}, 32'd0);
        check("idle_done", {31'b0, done_a}, 32'd0);

        // Golden run: 8000_0000 then 0 -> 0040_0007, pass.
        drive(0, 1'b1, 1'b0, 32'h0);
        tick();
        check("start_busy", {31'b0, busy_a}, 32'd1);
        drive(0, 1'b0, 1'b1, 32'h8000_0000);
        tick();
        check("gold_sig1", sig_a, 32'h8000_0000);
        check("gold_done_early", {31'b0, done_a}, 32'd0);
        exp_q_a.push_back({1'b1, 32'h0040_0007});
        drive(0, 1'b0, 1'b1, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        check("gold_done", {31'b0, done_a}, 32'd1);
        check("gold_busy", {31'b0, busy_a}, 32'd0);
        drain(0);

        // DONE ignores din_valid; signature and pass hold.
        drive(0, 1'b0, 1'b1, $urandom);
        repeat (3) tick();
        check("done_hold_sig", sig_a, 32'h0040_0007);
        check("done_hold_done", {31'b0, done_a}, 32'd1);
        check("done_hold_pass", {31'b0, pass_a}, 32'd1);

        // Restart from DONE; second word 1 -> 0040_0006, fail.
        drive(0, 1'b1, 1'b0, 32'h0);
        tick();
        check("restart_done", {31'b0, done_a}, 32'd0);
        check("restart_sig", sig_a, 32'h0);
        check("restart_busy", {31'b0, busy_a}, 32'd1);
        drive(0, 1'b0, 1'b1, 32'h8000_0000);
        tick();
        exp_q_a.push_back({1'b0, 32'h0040_0006});
        drive(0, 1'b0, 1'b1, 32'h0000_0001);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        drain(0);

        // start mid-COMPACT is ignored, including alongside a capture.
        w1 = $urandom;
        w2 = $urandom;
        drive(0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b0, 1'b1, w1);
        tick();
        drive(0, 1'b1, 1'b0, $urandom);
        tick();
        check("midstart_busy", {31'b0, busy_a}, 32'd1);
        check("midstart_sig", sig_a, step(32'h0, w1));
        exp_q_a.push_back({step(step(32'h0, w1), w2) == GOLDEN_A, step(step(32'h0, w1), w2)});
        drive(0, 1'b1, 1'b1, w2);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        drain(0);

        // Single-pattern instance with a long gap before its only capture.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        din_b = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_gap_done", {31'b0, done_b}, 32'd0);
        end
        check("b_gap_sig", sig_b, 32'h0);
        dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        check("b_done", {31'b0, done_b}, 32'd1);
        check("b_sig", sig_b, 32'h0000_0001);
        check("b_pass", {31'b0, pass_b}, 32'd1);

        // Asynchronous reset mid-COMPACT, checked before any clock edge.
        drive(0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        check("abort_pre_sig", sig_a, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sig", sig_a, 32'h0);
        check("async_busy", {31'b0, busy_a}, 32'd0);
        check("async_done", {31'b0, done_a}, 32'd0);
        check("async_b_done", {31'b0, done_b}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Fresh session after reset reproduces the golden signature.
        drive(0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b0, 1'b1, 32'h8000_0000);
        tick();
        exp_q_a.push_back({1'b1, 32'h0040_0007});
        drive(0, 1'b0, 1'b1, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        drain(0);

        // Randomized sessions on the 2-pattern instance.
        for (int s = 0; s < 12; s++) session(0, 2, 32'h0, GOLDEN_A, s[0]);

        // Full-range counter instance: 64 captures per session.
        for (int s = 0; s < 4; s++) begin
            session(2, 64, SEED_C, GOLDEN_C, s[0]);
            hold = sig_c;
            drive(2, 1'b0, 1'b1, $urandom);
            tick();
            drive(2, 1'b0, 1'b0, 32'h0);
            check("c_done_hold", sig_c, hold);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
